rv_trace_buffer: RTL and testbench

Parametrised retire-trace capture unit for the RV32 SoC. It observes up to NRET retire ports per cycle and classifies each retired instruction, 32-bit or compressed, into a fixed class set using the tracer instruction masks. Accepted records are buffered in a DEPTH-entry FIFO together with a cycle timestamp, and per-class retire counters are maintained. It sits beside the core's retire stage and drains over a valid/ready port to a trace sink (UART/debug DMA).

---
 rtl/rv_trace_buffer_if.sv | 23 ++
 rtl/rv_trace_buffer.sv | 189 ++++++++++++++++++
 tb/tb_rv_trace_buffer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/rv_trace_buffer_if.sv
// Drain-side stream of the retire-trace buffer: head record plus valid/ready.
// The buffer drives the master side and the trace sink uses the slave side.
interface rv_trace_buffer_if #(
  parameter int unsigned TS_W = 32
);
  logic            out_valid_o;
  logic            out_ready_i;
  logic [31:0]     out_pc_o;
  logic [31:0]     out_insn_o;
  logic [3:0]      out_class_o;
  logic            out_comp_o;
  logic [TS_W-1:0] out_ts_o;

  modport master (
    output out_valid_o, out_pc_o, out_insn_o, out_class_o, out_comp_o, out_ts_o,
    input  out_ready_i
  );

  modport slave (
    input  out_valid_o, out_pc_o, out_insn_o, out_class_o, out_comp_o, out_ts_o,
    output out_ready_i
  );
endinterface

// File: rtl/rv_trace_buffer.sv
// Retire-trace capture: classifies up to NRET retired instructions per cycle,
// counts them per class and buffers enabled ones with a timestamp in a FIFO.
module rv_trace_buffer #(
  parameter int unsigned NRET  = 2,
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 32,
  parameter int unsigned TS_W  = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [NRET-1:0]          ret_valid_i,
  input  logic [NRET*32-1:0]       ret_pc_i,
  input  logic [NRET*32-1:0]       ret_insn_i,
  input  logic [9:0]               class_en_i,
  input  logic                     clear_i,
  rv_trace_buffer_if.master        out_if,
  output logic [10*CNT_W-1:0]      cnt_o,
  output logic [CNT_W-1:0]         drop_cnt_o,
  output logic                     overflow_o,
  output logic [$clog2(DEPTH):0]   level_o
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  typedef enum logic [3:0] {
    CLS_OTHER  = 4'd0,
    CLS_ALU    = 4'd1,
    CLS_MULDIV = 4'd2,
    CLS_BRANCH = 4'd3,
    CLS_JUMP   = 4'd4,
    CLS_LOAD   = 4'd5,
    CLS_STORE  = 4'd6,
    CLS_SYSTEM = 4'd7,
    CLS_FENCE  = 4'd8,
    CLS_FP     = 4'd9
  } class_e;

  typedef struct packed {
    logic [31:0]     pc;
    logic [31:0]     insn;
    class_e          cls;
    logic            comp;
    logic [TS_W-1:0] ts;
  } rec_t;

  function automatic class_e classify(logic [31:0] insn);
    class_e c;
    c = CLS_OTHER;
    if (insn[1:0] != 2'b11) begin
      c = CLS_ALU;
      case ({insn[15:13], insn[1:0]})
        5'b010_00, 5'b010_10:                       c = CLS_LOAD;
        5'b110_00, 5'b110_10:                       c = CLS_STORE;
        5'b011_00, 5'b111_00, 5'b011_10, 5'b111_10: c = CLS_FP;
        5'b001_01, 5'b101_01:                       c = CLS_JUMP;
        5'b110_01, 5'b111_01:                       c = CLS_BRANCH;
        // C.JR / C.JALR / C.EBREAK share funct4 with C.MV / C.ADD; rs2==0 picks the jump group
        5'b100_10: if (insn[6:2] == 5'd0)
                     c = (insn[12] && insn[11:7] == 5'd0) ? CLS_SYSTEM : CLS_JUMP;
        default: ;
      endcase
    end else begin
      case (insn[6:2])
        5'b01100:                   c = (insn[31:25] == 7'b0000001) ? CLS_MULDIV : CLS_ALU;
        5'b00100, 5'b01101, 5'b00101: c = CLS_ALU;
        5'b11000:                   c = CLS_BRANCH;
        5'b11011, 5'b11001:         c = CLS_JUMP;
        5'b00000:                   c = CLS_LOAD;
        5'b01000:                   c = CLS_STORE;
        5'b11100:                   c = CLS_SYSTEM;
        5'b00011:                   c = CLS_FENCE;
        5'b00001, 5'b01001, 5'b10000, 5'b10001,
        5'b10010, 5'b10011, 5'b10100: c = CLS_FP;
        default: ;
      endcase
    end
    return c;
  endfunction

  rec_t             mem_q [DEPTH];
  rec_t             mem_d [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;
  logic [CNT_W-1:0] cnt_q [10];
  logic [CNT_W-1:0] cnt_d [10];
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             overflow_q, overflow_d;
  logic [TS_W-1:0]  ts_q, ts_d;

  class_e           cls [NRET];
  logic             pop;
  logic [LVL_W-1:0] free_slots, n_acc;
  logic [2:0]       n_drop, inc;
  logic [CNT_W:0]   sum;
  logic [31:0]      insn_w;

  always_comb begin
    mem_d      = mem_q;
    n_acc      = '0;
    n_drop     = '0;
    inc        = '0;
    sum        = '0;
    insn_w     = '0;
    pop        = (level_q != '0) && out_if.out_ready_i;
    // a same-cycle pop makes its slot available to this cycle's candidates
    free_slots = LVL_W'(DEPTH) - level_q + LVL_W'(pop);

    for (int unsigned p = 0; p < NRET; p++) begin
      insn_w = ret_insn_i[p*32 +: 32];
      cls[p] = classify(insn_w);
      if (ret_valid_i[p] && class_en_i[cls[p]]) begin
        if (n_acc < free_slots) begin
          mem_d[wr_ptr_q + PTR_W'(n_acc)].pc   = ret_pc_i[p*32 +: 32];
          mem_d[wr_ptr_q + PTR_W'(n_acc)].insn = (insn_w[1:0] == 2'b11) ? insn_w
                                                                       : {16'h0, insn_w[15:0]};
          mem_d[wr_ptr_q + PTR_W'(n_acc)].cls  = cls[p];
          mem_d[wr_ptr_q + PTR_W'(n_acc)].comp = (insn_w[1:0] != 2'b11);
          mem_d[wr_ptr_q + PTR_W'(n_acc)].ts   = ts_q;
          n_acc = n_acc + LVL_W'(1);
        end else begin
          n_drop = n_drop + 3'd1;
        end
      end
    end

    for (int unsigned k = 0; k < 10; k++) begin
      inc = '0;
      for (int unsigned p = 0; p < NRET; p++)
        if (ret_valid_i[p] && cls[p] == 4'(k)) inc = inc + 3'd1;
      sum      = {1'b0, cnt_q[k]} + (CNT_W+1)'(inc);
      cnt_d[k] = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    end

    sum        = {1'b0, drop_q} + (CNT_W+1)'(n_drop);
    drop_d     = sum[CNT_W] ? '1 : sum[CNT_W-1:0];
    overflow_d = overflow_q | (n_drop != '0);
    level_d    = level_q - LVL_W'(pop) + n_acc;
    wr_ptr_d   = wr_ptr_q + PTR_W'(n_acc);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    ts_d       = ts_q + TS_W'(1);

    if (clear_i) begin
      mem_d      = mem_q;
      cnt_d      = '{default: '0};
      drop_d     = '0;
      overflow_d = 1'b0;
      level_d    = '0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      ts_d       = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mem_q      <= '{default: '0};
      cnt_q      <= '{default: '0};
      drop_q     <= '0;
      overflow_q <= 1'b0;
      level_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      ts_q       <= '0;
    end else begin
      mem_q      <= mem_d;
      cnt_q      <= cnt_d;
      drop_q     <= drop_d;
      overflow_q <= overflow_d;
      level_q    <= level_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      ts_q       <= ts_d;
    end
  end

  for (genvar k = 0; k < 10; k++) begin : g_cnt
    assign cnt_o[k*CNT_W +: CNT_W] = cnt_q[k];
  end

  assign out_if.out_valid_o = (level_q != '0);
  assign out_if.out_pc_o    = mem_q[rd_ptr_q].pc;
  assign out_if.out_insn_o  = mem_q[rd_ptr_q].insn;
  assign out_if.out_class_o = mem_q[rd_ptr_q].cls;
  assign out_if.out_comp_o  = mem_q[rd_ptr_q].comp;
  assign out_if.out_ts_o    = mem_q[rd_ptr_q].ts;
  assign drop_cnt_o         = drop_q;
  assign overflow_o         = overflow_q;
  assign level_o            = level_q;
endmodule

// File: tb/tb_rv_trace_buffer.sv
// Bench for rv_trace_buffer: directed scenarios plus randomized retires checked
// against a queue-based model that classifies via an ordered mask/match table.
module tb_rv_trace_buffer;
  localparam int unsigned NRET  = 2;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned CNT_W = 4;
  localparam int unsigned TS_W  = 32;
  localparam int unsigned LVL_W = $clog2(DEPTH) + 1;
  localparam int unsigned CMAX  = (1 << CNT_W) - 1;

  typedef struct packed {
    logic [31:0] mask;
    logic [31:0] match;
    logic [3:0]  cls;
  } pat_t;

  localparam int NPAT = 34;
  localparam pat_t PAT [NPAT] = '{
    '{32'hFE00007F, 32'h02000033, 4'd2},
    '{32'h7F, 32'h33, 4'd1}, '{32'h7F, 32'h13, 4'd1}, '{32'h7F, 32'h37, 4'd1}, '{32'h7F, 32'h17, 4'd1},
    '{32'h7F, 32'h63, 4'd3}, '{32'h7F, 32'h6F, 4'd4}, '{32'h7F, 32'h67, 4'd4},
    '{32'h7F, 32'h03, 4'd5}, '{32'h7F, 32'h23, 4'd6}, '{32'h7F, 32'h73, 4'd7}, '{32'h7F, 32'h0F, 4'd8},
    '{32'h7F, 32'h07, 4'd9}, '{32'h7F, 32'h27, 4'd9}, '{32'h7F, 32'h43, 4'd9}, '{32'h7F, 32'h47, 4'd9},
    '{32'h7F, 32'h4B, 4'd9}, '{32'h7F, 32'h4F, 4'd9}, '{32'h7F, 32'h53, 4'd9},
    '{32'hFFFF, 32'h9002, 4'd7}, '{32'hF07F, 32'h8002, 4'd4}, '{32'hF07F, 32'h9002, 4'd4},
    '{32'hE003, 32'h4000, 4'd5}, '{32'hE003, 32'h6000, 4'd9}, '{32'hE003, 32'hC000, 4'd6},
    '{32'hE003, 32'hE000, 4'd9}, '{32'hE003, 32'h2001, 4'd4}, '{32'hE003, 32'hA001, 4'd4},
    '{32'hE003, 32'hC001, 4'd3}, '{32'hE003, 32'hE001, 4'd3}, '{32'hE003, 32'h4002, 4'd5},
    '{32'hE003, 32'h6002, 4'd9}, '{32'hE003, 32'hC002, 4'd6}, '{32'hE003, 32'hE002, 4'd9}
  };

  typedef struct {
    logic [31:0]     pc;
    logic [31:0]     insn;
    logic [3:0]      cls;
    logic            comp;
    logic [TS_W-1:0] ts;
  } trec_t;

  logic                  clk_i = 1'b0;
  logic                  rst_ni = 1'b1;
  logic [NRET-1:0]       ret_valid_i = '0;
  logic [NRET*32-1:0]    ret_pc_i = '0;
  logic [NRET*32-1:0]    ret_insn_i = '0;
  logic [9:0]            class_en_i = '1;
  logic                  clear_i = 1'b0;
  logic [10*CNT_W-1:0]   cnt_o;
  logic [CNT_W-1:0]      drop_cnt_o;
  logic                  overflow_o;
  logic [LVL_W-1:0]      level_o;

  rv_trace_buffer_if #(.TS_W(TS_W)) out_if ();

  rv_trace_buffer #(.NRET(NRET), .DEPTH(DEPTH), .CNT_W(CNT_W), .TS_W(TS_W)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .ret_valid_i(ret_valid_i), .ret_pc_i(ret_pc_i),
    .ret_insn_i(ret_insn_i), .class_en_i(class_en_i), .clear_i(clear_i), .out_if(out_if),
    .cnt_o(cnt_o), .drop_cnt_o(drop_cnt_o), .overflow_o(overflow_o), .level_o(level_o)
  );

  always #5 clk_i = ~clk_i;

  int          n_checks = 0;
  int          n_fail = 0;
  trec_t       mq[$];
  int unsigned m_cnt [10];
  int unsigned m_drop;
  bit          m_ovf;
  logic [31:0] m_ts;

  function automatic int ref_class(logic [31:0] w);
    logic [31:0] x;
    x = (w[1:0] == 2'b11) ? w : {16'h0, w[15:0]};
    for (int i = 0; i < NPAT; i++)
      if ((x & PAT[i].mask) == PAT[i].match) return int'(PAT[i].cls);
    return (w[1:0] == 2'b11) ? 0 : 1;
  endfunction

  function automatic logic [CNT_W-1:0] cnt_of(int k);
    return cnt_o[k*CNT_W +: CNT_W];
  endfunction

  task automatic model_reset();
    mq.delete();
    foreach (m_cnt[k]) m_cnt[k] = 0;
    m_drop = 0;
    m_ovf  = 1'b0;
    m_ts   = '0;
  endtask

  task automatic model_update();
    int unsigned freeslots, dropped;
    trec_t r;
    if (clear_i) begin
      model_reset();
      return;
    end
    freeslots = DEPTH - mq.size();
    if (mq.size() > 0 && out_if.out_ready_i) begin
      void'(mq.pop_front());
      freeslots++;
    end
    dropped = 0;
    for (int p = 0; p < NRET; p++) begin
      if (ret_valid_i[p]) begin
        logic [31:0] w;
        int c;
        w = ret_insn_i[p*32 +: 32];
        c = ref_class(w);
        m_cnt[c] = (m_cnt[c] < CMAX) ? m_cnt[c] + 1 : CMAX;
        if (class_en_i[c]) begin
          if (freeslots > 0) begin
            r.pc   = ret_pc_i[p*32 +: 32];
            r.comp = (w[1:0] != 2'b11);
            r.insn = r.comp ? {16'h0, w[15:0]} : w;
            r.cls  = 4'(c);
            r.ts   = m_ts;
            mq.push_back(r);
            freeslots--;
          end else begin
            dropped++;
          end
        end
      end
    end
    m_drop = (m_drop + dropped > CMAX) ? CMAX : m_drop + dropped;
    if (dropped > 0) m_ovf = 1'b1;
    m_ts = m_ts + 32'd1;
  endtask

  task automatic step();
    model_update();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle();
    ret_valid_i = '0;
    clear_i     = 1'b0;
  endtask

  task automatic set_port(int p, logic [31:0] pc, logic [31:0] insn);
    ret_valid_i[p]        = 1'b1;
    ret_pc_i[p*32 +: 32]   = pc;
    ret_insn_i[p*32 +: 32] = insn;
  endtask

  task automatic test_reset();
    out_if.out_ready_i = 1'b1;
    idle();
    #1 rst_ni = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_i);
    #1;
    n_checks++; if (out_if.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %0h expected 0", out_if.out_valid_o); end
    n_checks++; if (level_o !== '0) begin n_fail++; $display("FAIL reset_level: got %0d expected 0", level_o); end
    n_checks++; if (cnt_o !== '0) begin n_fail++; $display("FAIL reset_cnt: got %0h expected 0", cnt_o); end
    n_checks++; if (drop_cnt_o !== '0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL reset_drop: got %0d/%0b expected 0/0", drop_cnt_o, overflow_o); end
    n_checks++; if (out_if.out_pc_o !== '0 || out_if.out_ts_o !== '0 || out_if.out_insn_o !== '0) begin n_fail++; $display("FAIL reset_data: got pc %0h ts %0h insn %0h expected 0", out_if.out_pc_o, out_if.out_ts_o, out_if.out_insn_o); end
  endtask

  task automatic test_single_alu();
    rst_ni = 1'b1;
    set_port(0, 32'h8000_0000, 32'h0031_00B3);
    step();
    idle();
    n_checks++; if (out_if.out_valid_o !== 1'b1) begin n_fail++; $display("FAIL single_valid: got %0h expected 1", out_if.out_valid_o); end
    n_checks++; if (out_if.out_pc_o !== 32'h8000_0000) begin n_fail++; $display("FAIL single_pc: got %0h expected 80000000", out_if.out_pc_o); end
    n_checks++; if (out_if.out_class_o !== 4'd1 || out_if.out_comp_o !== 1'b0) begin n_fail++; $display("FAIL single_class: got %0d/%0b expected 1/0", out_if.out_class_o, out_if.out_comp_o); end
    n_checks++; if (out_if.out_ts_o !== 32'd0) begin n_fail++; $display("FAIL single_ts: got %0h expected 0", out_if.out_ts_o); end
    n_checks++; if (cnt_of(1) !== 4'd1) begin n_fail++; $display("FAIL single_alu_cnt: got %0d expected 1", cnt_of(1)); end
    step();
    n_checks++; if (level_o !== '0) begin n_fail++; $display("FAIL single_drain: got level %0d expected 0", level_o); end
  endtask

  task automatic test_dual_port();
    out_if.out_ready_i = 1'b0;
    set_port(0, 32'h8000_0004, 32'h0220_8033);
    set_port(1, 32'h8000_0008, 32'h0000_A001);
    step();
    idle();
    n_checks++; if (level_o !== 3'd2) begin n_fail++; $display("FAIL dual_level: got %0d expected 2", level_o); end
    n_checks++; if (out_if.out_class_o !== 4'd2 || out_if.out_insn_o !== 32'h0220_8033 || out_if.out_ts_o !== 32'd2) begin n_fail++; $display("FAIL dual_first: got cls %0d insn %0h ts %0d expected 2 02208033 2", out_if.out_class_o, out_if.out_insn_o, out_if.out_ts_o); end
    out_if.out_ready_i = 1'b1;
    step();
    n_checks++; if (out_if.out_class_o !== 4'd4 || out_if.out_comp_o !== 1'b1 || out_if.out_insn_o !== 32'h0000_A001) begin n_fail++; $display("FAIL dual_second: got cls %0d comp %0b insn %0h expected 4 1 0000a001", out_if.out_class_o, out_if.out_comp_o, out_if.out_insn_o); end
    n_checks++; if (out_if.out_ts_o !== 32'd2 || out_if.out_pc_o !== 32'h8000_0008) begin n_fail++; $display("FAIL dual_second_ts: got ts %0d pc %0h expected 2 80000008", out_if.out_ts_o, out_if.out_pc_o); end
    n_checks++; if (cnt_of(2) !== 4'd1 || cnt_of(4) !== 4'd1) begin n_fail++; $display("FAIL dual_cnt: got muldiv %0d jump %0d expected 1 1", cnt_of(2), cnt_of(4)); end
    step();
  endtask

  task automatic test_class_enable();
    out_if.out_ready_i = 1'b0;
    class_en_i = 10'h37F;
    set_port(0, 32'h8000_0010, 32'h3402_9073);
    set_port(1, 32'h8000_0014, 32'h0FF0_000F);
    step();
    idle();
    set_port(0, 32'h8000_0018, 32'h0010_0073);
    step();
    idle();
    n_checks++; if (level_o !== 3'd1 || out_if.out_class_o !== 4'd8) begin n_fail++; $display("FAIL en_stored: got level %0d cls %0d expected 1 8", level_o, out_if.out_class_o); end
    n_checks++; if (cnt_of(7) !== 4'd2 || cnt_of(8) !== 4'd1) begin n_fail++; $display("FAIL en_cnt: got system %0d fence %0d expected 2 1", cnt_of(7), cnt_of(8)); end
    class_en_i = '1;
    out_if.out_ready_i = 1'b1;
    step();
  endtask

  task automatic test_full_drop();
    clear_i = 1'b1;
    step();
    idle();
    n_checks++; if (cnt_o !== '0 || level_o !== '0) begin n_fail++; $display("FAIL clear_state: got cnt %0h level %0d expected 0 0", cnt_o, level_o); end
    out_if.out_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      set_port(0, 32'h1000 + 32'(c * 8), 32'h0010_8093);
      set_port(1, 32'h1004 + 32'(c * 8), 32'h0031_00B3);
      step();
    end
    idle();
    n_checks++; if (level_o !== 3'd4 || drop_cnt_o !== 4'd2 || overflow_o !== 1'b1) begin n_fail++; $display("FAIL full_drop: got level %0d drop %0d ovf %0b expected 4 2 1", level_o, drop_cnt_o, overflow_o); end
    n_checks++; if (cnt_of(1) !== 4'd6) begin n_fail++; $display("FAIL full_alu_cnt: got %0d expected 6", cnt_of(1)); end
    step();
    n_checks++; if (out_if.out_pc_o !== 32'h1000 || level_o !== 3'd4) begin n_fail++; $display("FAIL full_stable: got pc %0h level %0d expected 1000 4", out_if.out_pc_o, level_o); end
  endtask

  task automatic test_full_pop();
    logic [31:0] exp_pc [4];
    exp_pc[0] = 32'h1004; exp_pc[1] = 32'h1008; exp_pc[2] = 32'h100C; exp_pc[3] = 32'h2000;
    out_if.out_ready_i = 1'b1;
    set_port(0, 32'h2000, 32'h0010_8093);
    step();
    idle();
    n_checks++; if (level_o !== 3'd4 || drop_cnt_o !== 4'd2) begin n_fail++; $display("FAIL pop_push: got level %0d drop %0d expected 4 2", level_o, drop_cnt_o); end
    for (int i = 0; i < 4; i++) begin
      n_checks++; if (out_if.out_pc_o !== exp_pc[i]) begin n_fail++; $display("FAIL pop_order%0d: got %0h expected %0h", i, out_if.out_pc_o, exp_pc[i]); end
      step();
    end
    n_checks++; if (out_if.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL pop_empty: got %0b expected 0", out_if.out_valid_o); end
  endtask

  task automatic test_saturation();
    out_if.out_ready_i = 1'b0;
    for (int c = 0; c < 10; c++) begin
      set_port(0, 32'h3000 + 32'(c * 8), 32'h0010_8093);
      set_port(1, 32'h3004 + 32'(c * 8), 32'h0010_8093);
      step();
    end
    idle();
    n_checks++; if (cnt_of(1) !== 4'hF || drop_cnt_o !== 4'hF) begin n_fail++; $display("FAIL saturate: got alu %0d drop %0d expected 15 15", cnt_of(1), drop_cnt_o); end
    n_checks++; if (level_o !== 3'd4 || out_if.out_pc_o !== 32'h3000) begin n_fail++; $display("FAIL saturate_fifo: got level %0d pc %0h expected 4 3000", level_o, out_if.out_pc_o); end
  endtask

  task automatic test_clear_reset();
    clear_i = 1'b1;
    out_if.out_ready_i = 1'b1;
    set_port(0, 32'h4000, 32'h0010_8093);
    step();
    idle();
    n_checks++; if (cnt_o !== '0 || level_o !== '0 || out_if.out_valid_o !== 1'b0) begin n_fail++; $display("FAIL clear_retire: got cnt %0h level %0d valid %0b expected 0 0 0", cnt_o, level_o, out_if.out_valid_o); end
    n_checks++; if (drop_cnt_o !== '0 || overflow_o !== 1'b0) begin n_fail++; $display("FAIL clear_drop: got %0d/%0b expected 0/0", drop_cnt_o, overflow_o); end
    out_if.out_ready_i = 1'b0;
    set_port(0, 32'h5000, 32'h0000_4004);
    set_port(1, 32'h5002, 32'h0000_C004);
    step();
    idle();
    set_port(0, 32'h5004, 32'h0000_0063);
    step();
    idle();
    out_if.out_ready_i = 1'b1;
    step();
    n_checks++; if (level_o !== 3'd2 || out_if.out_class_o !== 4'd6) begin n_fail++; $display("FAIL drain_mid: got level %0d cls %0d expected 2 6", level_o, out_if.out_class_o); end
    #2 rst_ni = 1'b0;
    model_reset();
    #1;
    n_checks++; if (out_if.out_valid_o !== 1'b0 || level_o !== '0) begin n_fail++; $display("FAIL async_reset: got valid %0b level %0d expected 0 0", out_if.out_valid_o, level_o); end
    n_checks++; if (cnt_o !== '0 || overflow_o !== 1'b0 || out_if.out_pc_o !== '0) begin n_fail++; $display("FAIL async_reset_state: got cnt %0h ovf %0b pc %0h expected 0", cnt_o, overflow_o, out_if.out_pc_o); end
    @(posedge clk_i);
    #1 rst_ni = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] w;
    int unsigned k;
    for (int cyc = 0; cyc < 400; cyc++) begin
      clear_i = ($urandom_range(79) == 0);
      class_en_i = ($urandom_range(3) == 0) ? 10'($urandom) : '1;
      out_if.out_ready_i = ($urandom_range(2) != 0);
      for (int p = 0; p < NRET; p++) begin
        w = $urandom;
        if ($urandom_range(3) != 0) begin
          k = $urandom_range(NPAT - 1);
          w = (w & ~PAT[k].mask) | PAT[k].match;
        end
        ret_valid_i[p] = ($urandom_range(3) != 0);
        ret_pc_i[p*32 +: 32] = $urandom & 32'hFFFF_FFFE;
        ret_insn_i[p*32 +: 32] = w;
      end
      step();
      n_checks++; if (level_o !== LVL_W'(mq.size())) begin n_fail++; $display("FAIL rnd_level c%0d: got %0d expected %0d", cyc, level_o, mq.size()); end
      n_checks++; if (out_if.out_valid_o !== (mq.size() != 0)) begin n_fail++; $display("FAIL rnd_valid c%0d: got %0b expected %0b", cyc, out_if.out_valid_o, mq.size() != 0); end
      if (mq.size() != 0) begin
        n_checks++; if (out_if.out_pc_o !== mq[0].pc || out_if.out_insn_o !== mq[0].insn) begin n_fail++; $display("FAIL rnd_head c%0d: got pc %0h insn %0h expected %0h %0h", cyc, out_if.out_pc_o, out_if.out_insn_o, mq[0].pc, mq[0].insn); end
        n_checks++; if (out_if.out_class_o !== mq[0].cls || out_if.out_comp_o !== mq[0].comp || out_if.out_ts_o !== mq[0].ts) begin n_fail++; $display("FAIL rnd_meta c%0d: got cls %0d comp %0b ts %0d expected %0d %0b %0d", cyc, out_if.out_class_o, out_if.out_comp_o, out_if.out_ts_o, mq[0].cls, mq[0].comp, mq[0].ts); end
      end
      for (int c = 0; c < 10; c++) begin
        n_checks++; if (cnt_of(c) !== CNT_W'(m_cnt[c])) begin n_fail++; $display("FAIL rnd_cnt%0d c%0d: got %0d expected %0d", c, cyc, cnt_of(c), m_cnt[c]); end
      end
      n_checks++; if (drop_cnt_o !== CNT_W'(m_drop) || overflow_o !== m_ovf) begin n_fail++; $display("FAIL rnd_drop c%0d: got %0d/%0b expected %0d/%0b", cyc, drop_cnt_o, overflow_o, m_drop, m_ovf); end
    end
    idle();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single_alu();
    test_dual_port();
    test_class_enable();
    test_full_drop();
    test_full_pop();
    test_saturation();
    test_clear_reset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
